// File: rtl/cnn_conv_classifier.sv
// cnn_conv_classifier: binary-weight KxK convolution + ReLU + sum-pool per channel, argmax over channels; ports CLK/RST (async high), START in, IMGIN/WGT data in, BUSY/DONE status out, OUT/SCORE winning class and score out
module cnn_conv_classifier #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 20,
  parameter int K = 3,
  parameter int NCH = 10,
  localparam int OUT_W = $clog2(NCH),
  localparam int NW = (IMG_H-K+1)*(IMG_W-K+1),
  localparam int SW = $clog2(K*K*NW+1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [IMG_W*IMG_H-1:0] IMGIN,
  input  logic [NCH*K*K-1:0]     WGT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [OUT_W-1:0]       OUT,
  output logic [SW-1:0]          SCORE
);
  localparam int XW = $clog2(IMG_W+1);
  localparam int YW = $clog2(IMG_H+1);
  localparam int PW = $clog2(IMG_W*IMG_H+1);
  localparam int WW = $clog2(NCH*K*K+1);
  localparam int CW = $clog2(K*K+1);
  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
  state_t state_q, state_d;
  logic [IMG_W*IMG_H-1:0] img_q, img_d;
  logic [NCH*K*K-1:0] wgt_q, wgt_d;
  logic [OUT_W-1:0] ch_q, ch_d, bidx_q, bidx_d, out_q, out_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] x_q, x_d;
  logic [SW-1:0] acc_q, acc_d, best_q, best_d, score_q, score_d;
  logic [CW-1:0] p, n, r;
  logic [PW-1:0] pi;
  logic [WW-1:0] wi;
  logic [SW-1:0] s, nb;
  logic [OUT_W-1:0] ni;
  logic upd;
  // p counts lit pixels under +1 weights, n under -1 weights; v = p - n
  always_comb begin
    p = '0;
    n = '0;
    pi = '0;
    wi = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        pi = PW'((int'(y_q)+i)*IMG_W + int'(x_q) + j);
        wi = WW'(int'(ch_q)*K*K + i*K + j);
        p = p + CW'(img_q[pi] & wgt_q[wi]);
        n = n + CW'(img_q[pi] & ~wgt_q[wi]);
      end
    r = (p > n) ? p - n : '0;
    s = acc_q + SW'(r);
    upd = (ch_q == '0) || (s > best_q);
    nb = upd ? s : best_q;
    ni = upd ? ch_q : bidx_q;
  end
  always_comb begin
    state_d = state_q;
    img_d = img_q;
    wgt_d = wgt_q;
    ch_d = ch_q;
    y_d = y_q;
    x_d = x_q;
    acc_d = acc_q;
    best_d = best_q;
    bidx_d = bidx_q;
    out_d = out_q;
    score_d = score_q;
    if (START && state_q != CONV) begin
      state_d = CONV;
      img_d = IMGIN;
      wgt_d = WGT;
      ch_d = '0;
      y_d = '0;
      x_d = '0;
      acc_d = '0;
      best_d = '0;
      bidx_d = '0;
    end else if (state_q == CONV) begin
      acc_d = s;
      x_d = x_q + 1'b1;
      if (x_q == XW'(IMG_W-K)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
        if (y_q == YW'(IMG_H-K)) begin
          y_d = '0;
          acc_d = '0;
          best_d = nb;
          bidx_d = ni;
          ch_d = ch_q + 1'b1;
          if (ch_q == OUT_W'(NCH-1)) begin
            ch_d = '0;
            state_d = FIN;
            out_d = ni;
            score_d = nb;
          end
        end
      end
    end else if (state_q == FIN) state_d = IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      img_q <= '0;
      wgt_q <= '0;
      ch_q <= '0;
      y_q <= '0;
      x_q <= '0;
      acc_q <= '0;
      best_q <= '0;
      bidx_q <= '0;
      out_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      img_q <= img_d;
      wgt_q <= wgt_d;
      ch_q <= ch_d;
      y_q <= y_d;
      x_q <= x_d;
      acc_q <= acc_d;
      best_q <= best_d;
      bidx_q <= bidx_d;
      out_q <= out_d;
      score_q <= score_d;
    end
  assign BUSY = state_q == CONV;
  assign DONE = state_q == FIN;
  assign OUT = out_q;
  assign SCORE = score_q;
endmodule

// File: doc/cnn_conv_classifier.md
# cnn_conv_classifier

Parametrised successor to the fixed-size simple CNN. It takes a binary image and a bank of NCH binary-weight KxK kernels and performs a stride-1 valid convolution per channel, with ReLU on each window. It sum-pools each channel into a class score and reports the argmax class. It sits between the image/weight source and the result logic, using a START/DONE handshake.

## Interface
- IMG_W, 10, image width in pixels
- IMG_H, 20, image height in pixels
- K, 3, kernel side (K <= IMG_W, K <= IMG_H)
- NCH, 10, channel/class count (>= 2)
- OUT_W (localparam), $clog2(NCH), class index width (4 at defaults)
- NW (localparam), (IMG_H-K+1)*(IMG_W-K+1), windows per channel (144 at defaults)
- SW (localparam), $clog2(K*K*NW+1), score width (11 at defaults)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  request a classification; sampled on CLK
- IMGIN  in  IMG_W*IMG_H  pixel (r,c) = IMGIN[r*IMG_W+c]; 1 = on
- WGT  in  NCH*K*K  weight (ch,i,j) = WGT[ch*K*K+i*K+j]; 1 = +1, 0 = -1
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle result pulse
- OUT  out  OUT_W  winning class index
- SCORE  out  SW  winning class score

## Operation
- States: IDLE, CONV, FIN.
- IDLE or FIN with START=1 at an edge:
  - capture IMGIN and WGT into internal registers; inputs may change afterwards;
  - clear the window counters (ch, y, x), the accumulator, and the best score/index;
  - go to CONV.
- START in CONV is ignored.
- CONV evaluates exactly one window per cycle, in order ch-major, then y (0..IMG_H-K), then x (0..IMG_W-K).
- Window value: v = sum over i,j in 0..K-1 of (pixel(y+i,x+j) ? w(ch,i,j) : 0).
  - Signed range is -K*K..+K*K.
  - ReLU: r = max(v,0).
- Channel score: S(ch) = sum of r over all NW windows. Unsigned, SW bits; it cannot overflow by construction.
- On the last window of a channel:
  - compare the final S(ch), which includes the current r, against best;
  - update best/index only if S(ch) > best (strict), so ties keep the lower index;
  - channel 0 always loads;
  - clear the accumulator for the next channel.
- After the last window of channel NCH-1, go to FIN.
  - OUT and SCORE are loaded from best/index on that transition.
- FIN lasts one cycle (DONE=1) and then returns to IDLE, unless START is accepted in that cycle.
- OUT and SCORE hold until the next result is loaded. They are not cleared on START.

## Timing
- Reset values: BUSY=0, DONE=0, OUT=0, SCORE=0, state IDLE, all counters and accumulators 0.
- Reset is asynchronous and effective immediately.
- Let E0 be the edge that accepts START.
  - BUSY=1 from E0 until edge E0+N, where N = NCH*NW (1440 at defaults).
  - Windows are evaluated in cycles E0+1..E0+N.
  - The edge E0+N loads OUT/SCORE, sets DONE=1 and BUSY=0.
  - DONE falls at E0+N+1.
- Latency from START edge to DONE high is N cycles; DONE is visible in the cycle after edge E0+N.
- Back-to-back: START=1 during the FIN cycle restarts at that edge. DONE still pulses that cycle, and BUSY rises at the same edge.
- Reset mid-CONV aborts the operation: no DONE is produced, and OUT/SCORE return to 0.
- Throughput is one window per cycle, with no stalls.

## Test plan
- Reset: assert RST asynchronously mid-cycle. BUSY, DONE, OUT and SCORE must be 0 immediately and stay so with START=0.
- All-zero image, random WGT: DONE rises exactly 1440 cycles after the START edge, lasts 1 cycle; OUT=0, SCORE=0 (all ties, lowest index).
- All-ones image, WGT channel 7 all 1s, others all 0s: S(7)=144*9=1296, other channels 0 after ReLU; OUT=7, SCORE=1296.
- All-ones image, channels 3 and 5 all 1s, others all 0s: tie at 1296 gives OUT=3, SCORE=1296. Then swap so only channel 9 is all 1s, to check that the last channel wins (OUT=9).
- Corner windows:
  - Only pixel (19,9) on; channel 4 has w(2,2)=+1 and the rest -1; all other channels all 0s. Expect OUT=4, SCORE=1.
  - Repeat with pixel (0,0) and channel 2, w(0,0)=+1. Expect OUT=2, SCORE=1.
- Protocol:
  - START pulsed again at cycle 200 of a run is ignored; DONE still arrives at cycle 1440.
  - RST at cycle 500: no DONE, outputs 0. A fresh START then completes normally.
  - START held high through FIN restarts a run: DONE pulses, BUSY is high the next cycle, and the next DONE arrives 1440 cycles later.
